// File: rtl/cache_arbiter.sv
// Two-to-one arbiter that shares one downstream memory port between the I-cache and the D-cache.
// Ties go to the side that was not granted last. Every transaction ends with one idle cycle.
module cache_arbiter (
  input  logic         clk,
  input  logic         rst,

  input  logic         i_pmem_read,
  input  logic [31:0]  i_pmem_addr,
  output logic [255:0] i_pmem_rdata,
  output logic         i_pmem_resp,

  input  logic         d_pmem_read,
  input  logic         d_pmem_write,
  input  logic [31:0]  d_pmem_addr,
  input  logic [255:0] d_pmem_wdata,
  output logic [255:0] d_pmem_rdata,
  output logic         d_pmem_resp,

  output logic         mem_read,
  output logic         mem_write,
  output logic [31:0]  mem_addr,
  output logic [255:0] mem_wdata,
  input  logic [255:0] mem_rdata,
  input  logic         mem_resp
);

  // Handshake: a requester raises read/write with stable address and data, and holds
  // them until its resp pulses for one cycle. The downstream side sees read/write
  // drop for at least one cycle between transactions, and answers with one mem_resp pulse.
  typedef enum logic [1:0] {
    IDLE    = 2'd0,
    SERVE_I = 2'd1,
    SERVE_D = 2'd2
  } state_t;

  state_t state;
  logic   last_grant;  // 0 = I-cache, 1 = D-cache
  logic   i_req;
  logic   d_req;

  assign i_req = i_pmem_read;
  assign d_req = d_pmem_read | d_pmem_write;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state      <= IDLE;
      last_grant <= 1'b0;
    end else begin
      case (state)
        IDLE: begin
          if (i_req && d_req) begin
            if (last_grant) begin
              state      <= SERVE_I;
              last_grant <= 1'b0;
            end else begin
              state      <= SERVE_D;
              last_grant <= 1'b1;
            end
          end else if (i_req) begin
            state      <= SERVE_I;
            last_grant <= 1'b0;
          end else if (d_req) begin
            state      <= SERVE_D;
            last_grant <= 1'b1;
          end
        end
        // A requester that drops its request early is abandoned.
        SERVE_I: if (mem_resp || !i_req) state <= IDLE;
        SERVE_D: if (mem_resp || !d_req) state <= IDLE;
        default: state <= IDLE;
      endcase
    end
  end

  // The data and response paths are pure muxes on the registered state, so mem_resp
  // reaches the served cache with no added latency.
  always_comb begin
    mem_read     = 1'b0;
    mem_write    = 1'b0;
    mem_addr     = 32'h0;
    mem_wdata    = 256'h0;
    i_pmem_rdata = 256'h0;
    i_pmem_resp  = 1'b0;
    d_pmem_rdata = 256'h0;
    d_pmem_resp  = 1'b0;
    if (!rst) begin
      case (state)
        SERVE_I: begin
          mem_read     = i_pmem_read;
          mem_addr     = i_pmem_addr;
          i_pmem_rdata = mem_rdata;
          i_pmem_resp  = mem_resp & i_req;
        end
        SERVE_D: begin
          mem_read     = d_pmem_read;
          mem_write    = d_pmem_write;
          mem_addr     = d_pmem_addr;
          mem_wdata    = d_pmem_wdata;
          d_pmem_rdata = mem_rdata;
          d_pmem_resp  = mem_resp & d_req;
        end
        default: ;
      endcase
    end
  end

endmodule

// File: tb/tb_cache_arbiter.sv
// Directed bench for cache_arbiter: inputs change 1ns after the rising edge, outputs are checked on the falling edge.
module tb_cache_arbiter;

  logic         clk = 1'b0;
  logic         rst;
  logic         i_pmem_read;
  logic [31:0]  i_pmem_addr;
  logic [255:0] i_pmem_rdata;
  logic         i_pmem_resp;
  logic         d_pmem_read;
  logic         d_pmem_write;
  logic [31:0]  d_pmem_addr;
  logic [255:0] d_pmem_wdata;
  logic [255:0] d_pmem_rdata;
  logic         d_pmem_resp;
  logic         mem_read;
  logic         mem_write;
  logic [31:0]  mem_addr;
  logic [255:0] mem_wdata;
  logic [255:0] mem_rdata;
  logic         mem_resp;

  int checks = 0;
  int failures = 0;

  logic [3:0]   flags;
  logic [803:0] all_out;
  assign flags   = {mem_read, mem_write, i_pmem_resp, d_pmem_resp};
  assign all_out = {flags, mem_addr, mem_wdata, i_pmem_rdata, d_pmem_rdata};

  cache_arbiter dut (
    .clk          (clk),
    .rst          (rst),
    .i_pmem_read  (i_pmem_read),
    .i_pmem_addr  (i_pmem_addr),
    .i_pmem_rdata (i_pmem_rdata),
    .i_pmem_resp  (i_pmem_resp),
    .d_pmem_read  (d_pmem_read),
    .d_pmem_write (d_pmem_write),
    .d_pmem_addr  (d_pmem_addr),
    .d_pmem_wdata (d_pmem_wdata),
    .d_pmem_rdata (d_pmem_rdata),
    .d_pmem_resp  (d_pmem_resp),
    .mem_read     (mem_read),
    .mem_write    (mem_write),
    .mem_addr     (mem_addr),
    .mem_wdata    (mem_wdata),
    .mem_rdata    (mem_rdata),
    .mem_resp     (mem_resp)
  );

  always #5 clk = ~clk;

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic sample();
    @(negedge clk);
  endtask

  task automatic clear_inputs();
    i_pmem_read  = 1'b0;
    i_pmem_addr  = 32'h0;
    d_pmem_read  = 1'b0;
    d_pmem_write = 1'b0;
    d_pmem_addr  = 32'h0;
    d_pmem_wdata = 256'h0;
    mem_rdata    = 256'h0;
    mem_resp     = 1'b0;
  endtask

  task automatic do_reset();
    rst = 1'b1;
    clear_inputs();
    tick();
    tick();
    rst = 1'b0;
  endtask

  task automatic test_reset();
    rst = 1'b1;
    clear_inputs();
    tick();
    d_pmem_read = 1'b1;
    mem_resp    = 1'b1;
    sample();
    checks++;
    if (all_out !== '0) begin
      failures++;
      $display("FAIL reset_hold outputs nonzero got flags=%b addr=%h exp all zero", flags, mem_addr);
    end
    tick();
    rst = 1'b0;
    clear_inputs();
    sample();
    checks++;
    if (all_out !== '0) begin
      failures++;
      $display("FAIL reset_release outputs nonzero got flags=%b addr=%h exp all zero", flags, mem_addr);
    end
  endtask

  task automatic test_single_i_read();
    logic [255:0] rd = {8{32'hA5A5_0001}};
    tick();
    i_pmem_read = 1'b1;
    i_pmem_addr = 32'h0000_1000;
    sample();
    checks++;
    if (flags !== 4'b0000) begin failures++; $display("FAIL i_read_seen flags got=%b exp=0000", flags); end
    tick();
    sample();
    checks++;
    if (flags !== 4'b1000 || mem_addr !== 32'h0000_1000) begin
      failures++; $display("FAIL i_read_grant flags=%b addr=%h exp 1000 addr=00001000", flags, mem_addr);
    end
    tick();
    sample();
    checks++;
    if (flags !== 4'b1000) begin failures++; $display("FAIL i_read_wait flags got=%b exp=1000", flags); end
    tick();
    mem_resp  = 1'b1;
    mem_rdata = rd;
    sample();
    checks++;
    if (flags !== 4'b1010 || i_pmem_rdata !== rd || d_pmem_rdata !== 256'h0) begin
      failures++; $display("FAIL i_read_resp flags=%b irdata_ok=%0b exp 1010 with rdata", flags, i_pmem_rdata === rd);
    end
    tick();
    mem_resp    = 1'b0;
    i_pmem_read = 1'b0;
    sample();
    checks++;
    if (flags !== 4'b0000 || i_pmem_rdata !== 256'h0) begin
      failures++; $display("FAIL i_read_idle flags got=%b exp=0000", flags);
    end
  endtask

  task automatic test_both_from_reset();
    logic [255:0] r1 = {8{32'hD00D_0001}};
    logic [255:0] r2 = {8{32'h1CE0_0002}};
    do_reset();
    i_pmem_read = 1'b1;
    i_pmem_addr = 32'h0000_3000;
    d_pmem_read = 1'b1;
    d_pmem_addr = 32'h0000_4000;
    sample();
    tick();
    sample();
    checks++;
    if (flags !== 4'b1000 || mem_addr !== 32'h0000_4000) begin
      failures++; $display("FAIL both_first_d flags=%b addr=%h exp 1000 addr=00004000", flags, mem_addr);
    end
    tick();
    mem_resp  = 1'b1;
    mem_rdata = r1;
    sample();
    checks++;
    if (flags !== 4'b1001 || d_pmem_rdata !== r1 || i_pmem_rdata !== 256'h0) begin
      failures++; $display("FAIL both_d_resp flags=%b exp 1001", flags);
    end
    tick();
    mem_resp    = 1'b0;
    d_pmem_read = 1'b0;
    sample();
    checks++;
    if (flags !== 4'b0000) begin failures++; $display("FAIL both_gap flags got=%b exp=0000", flags); end
    tick();
    sample();
    checks++;
    if (flags !== 4'b1000 || mem_addr !== 32'h0000_3000) begin
      failures++; $display("FAIL both_then_i flags=%b addr=%h exp 1000 addr=00003000", flags, mem_addr);
    end
    tick();
    mem_resp  = 1'b1;
    mem_rdata = r2;
    sample();
    checks++;
    if (flags !== 4'b1010 || i_pmem_rdata !== r2) begin
      failures++; $display("FAIL both_i_resp flags=%b exp 1010", flags);
    end
    tick();
    clear_inputs();
    sample();
    checks++;
    if (flags !== 4'b0000) begin failures++; $display("FAIL both_end flags got=%b exp=0000", flags); end
  endtask

  task automatic test_d_write_immediate();
    logic [255:0] wd = {8{32'hBEEF_2040}};
    tick();
    d_pmem_write = 1'b1;
    d_pmem_addr  = 32'h0000_2040;
    d_pmem_wdata = wd;
    sample();
    tick();
    mem_resp = 1'b1;
    sample();
    checks++;
    if (flags !== 4'b0101 || mem_addr !== 32'h0000_2040 || mem_wdata !== wd) begin
      failures++; $display("FAIL dwrite_resp flags=%b addr=%h exp 0101 addr=00002040", flags, mem_addr);
    end
    tick();
    mem_resp     = 1'b0;
    d_pmem_write = 1'b0;
    sample();
    checks++;
    if (flags !== 4'b0000 || mem_wdata !== 256'h0) begin
      failures++; $display("FAIL dwrite_after flags got=%b exp=0000", flags);
    end
  endtask

  task automatic test_read_write_both();
    tick();
    d_pmem_read  = 1'b1;
    d_pmem_write = 1'b1;
    d_pmem_addr  = 32'h0000_5000;
    tick();
    sample();
    checks++;
    if (flags !== 4'b1100) begin failures++; $display("FAIL rw_forward flags got=%b exp=1100", flags); end
    tick();
    mem_resp = 1'b1;
    sample();
    tick();
    clear_inputs();
  endtask

  task automatic test_alternation();
    logic [31:0] exp_addr;
    logic [3:0]  exp_resp;
    do_reset();
    i_pmem_read = 1'b1;
    i_pmem_addr = 32'h0000_6000;
    d_pmem_read = 1'b1;
    d_pmem_addr = 32'h0000_7000;
    sample();
    for (int k = 0; k < 6; k++) begin
      exp_addr = (k % 2 == 0) ? 32'h0000_7000 : 32'h0000_6000;
      exp_resp = (k % 2 == 0) ? 4'b1001 : 4'b1010;
      tick();
      sample();
      checks++;
      if (flags !== 4'b1000 || mem_addr !== exp_addr) begin
        failures++; $display("FAIL alt_grant_%0d flags=%b addr=%h exp 1000 addr=%h", k, flags, mem_addr, exp_addr);
      end
      tick();
      mem_resp = 1'b1;
      sample();
      checks++;
      if (flags !== exp_resp) begin
        failures++; $display("FAIL alt_resp_%0d flags got=%b exp=%b", k, flags, exp_resp);
      end
      tick();
      mem_resp = 1'b0;
      if (k == 5) begin
        i_pmem_read = 1'b0;
        d_pmem_read = 1'b0;
      end
      sample();
      checks++;
      if (flags !== 4'b0000) begin failures++; $display("FAIL alt_gap_%0d flags got=%b exp=0000", k, flags); end
    end
    clear_inputs();
  endtask

  task automatic test_reset_mid_serve();
    tick();
    d_pmem_read = 1'b1;
    d_pmem_addr = 32'h0000_8000;
    tick();
    sample();
    checks++;
    if (flags !== 4'b1000) begin failures++; $display("FAIL rstmid_grant flags got=%b exp=1000", flags); end
    #2;
    rst = 1'b1;
    #1;
    checks++;
    if (all_out !== '0) begin
      failures++; $display("FAIL rstmid_async flags=%b addr=%h exp all zero", flags, mem_addr);
    end
    tick();
    mem_resp = 1'b1;
    sample();
    checks++;
    if (all_out !== '0) begin
      failures++; $display("FAIL rstmid_resp flags=%b exp all zero", flags);
    end
    tick();
    rst         = 1'b0;
    d_pmem_read = 1'b0;
    sample();
    checks++;
    if (flags !== 4'b0000) begin failures++; $display("FAIL rstmid_stray_resp flags got=%b exp=0000", flags); end
    tick();
    mem_resp    = 1'b0;
    i_pmem_read = 1'b1;
    i_pmem_addr = 32'h0000_9000;
    sample();
    tick();
    sample();
    checks++;
    if (flags !== 4'b1000 || mem_addr !== 32'h0000_9000) begin
      failures++; $display("FAIL rstmid_regrant flags=%b addr=%h exp 1000 addr=00009000", flags, mem_addr);
    end
    tick();
    mem_resp = 1'b1;
    sample();
    checks++;
    if (flags !== 4'b1010) begin failures++; $display("FAIL rstmid_i_resp flags got=%b exp=1010", flags); end
    tick();
    clear_inputs();
  endtask

  task automatic test_protocol_violation();
    tick();
    i_pmem_read = 1'b1;
    i_pmem_addr = 32'h0000_A000;
    tick();
    sample();
    checks++;
    if (flags !== 4'b1000) begin failures++; $display("FAIL drop_grant flags got=%b exp=1000", flags); end
    tick();
    i_pmem_read = 1'b0;
    mem_resp    = 1'b1;
    sample();
    checks++;
    if (flags !== 4'b0000) begin failures++; $display("FAIL drop_no_resp flags got=%b exp=0000", flags); end
    tick();
    mem_resp    = 1'b0;
    d_pmem_read = 1'b1;
    d_pmem_addr = 32'h0000_B000;
    sample();
    checks++;
    if (flags !== 4'b0000) begin failures++; $display("FAIL drop_idle flags got=%b exp=0000", flags); end
    tick();
    sample();
    checks++;
    if (flags !== 4'b1000 || mem_addr !== 32'h0000_B000) begin
      failures++; $display("FAIL drop_next_d flags=%b addr=%h exp 1000 addr=0000b000", flags, mem_addr);
    end
    tick();
    mem_resp = 1'b1;
    sample();
    tick();
    clear_inputs();
  endtask

  task automatic test_back_to_back();
    tick();
    d_pmem_read = 1'b1;
    d_pmem_addr = 32'h0000_C000;
    tick();
    sample();
    checks++;
    if (flags !== 4'b1000 || mem_addr !== 32'h0000_C000) begin
      failures++; $display("FAIL b2b_first flags=%b addr=%h exp 1000 addr=0000c000", flags, mem_addr);
    end
    tick();
    mem_resp = 1'b1;
    sample();
    checks++;
    if (flags !== 4'b1001) begin failures++; $display("FAIL b2b_first_resp flags got=%b exp=1001", flags); end
    tick();
    mem_resp    = 1'b0;
    d_pmem_addr = 32'h0000_C020;
    sample();
    checks++;
    if (mem_read !== 1'b0) begin failures++; $display("FAIL b2b_gap mem_read got=%b exp=0", mem_read); end
    tick();
    sample();
    checks++;
    if (flags !== 4'b1000 || mem_addr !== 32'h0000_C020) begin
      failures++; $display("FAIL b2b_second flags=%b addr=%h exp 1000 addr=0000c020", flags, mem_addr);
    end
    tick();
    mem_resp = 1'b1;
    sample();
    checks++;
    if (flags !== 4'b1001) begin failures++; $display("FAIL b2b_second_resp flags got=%b exp=1001", flags); end
    tick();
    clear_inputs();
    sample();
    checks++;
    if (flags !== 4'b0000) begin failures++; $display("FAIL b2b_end flags got=%b exp=0000", flags); end
  endtask

  initial begin
    test_reset();
    test_single_i_read();
    test_both_from_reset();
    test_d_write_immediate();
    test_read_write_both();
    test_alternation();
    test_reset_mid_serve();
    test_protocol_violation();
    test_back_to_back();
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule

// File: doc/cache_arbiter.md
CACHE_ARBITER -- requirements
Module: cache_arbiter

Interface
REQ-001 Parameters SHALL be none; all widths are fixed.
REQ-002 clk  input  1  single clock; all state updates on rising edge.
REQ-003 rst  input  1  asynchronous, active-high reset.
REQ-004 i_pmem_read  input  1  I-cache line-fill request.
REQ-005 i_pmem_addr  input  32  I-cache line address.
REQ-006 i_pmem_rdata  output  256  line data to I-cache.
REQ-007 i_pmem_resp  output  1  I-cache transaction complete.
REQ-008 d_pmem_read  input  1  D-cache line-fill request.
REQ-009 d_pmem_write  input  1  D-cache writeback request.
REQ-010 d_pmem_addr  input  32  D-cache line address.
REQ-011 d_pmem_wdata  input  256  D-cache writeback data.
REQ-012 d_pmem_rdata  output  256  line data to D-cache.
REQ-013 d_pmem_resp  output  1  D-cache transaction complete.
REQ-014 mem_read  output  1  read request to downstream write buffer.
REQ-015 mem_write  output  1  write request to downstream write buffer.
REQ-016 mem_addr  output  32  downstream address.
REQ-017 mem_wdata  output  256  downstream write data.
REQ-018 mem_rdata  input  256  downstream read data.
REQ-019 mem_resp  input  1  downstream completion, single-cycle pulse.

Function
REQ-020 States SHALL be IDLE, SERVE_I, SERVE_D, plus a 1-bit register last_grant (0 = I, 1 = D).
REQ-021 Requesters SHALL hold request, address and data stable until their resp; the arbiter relies on this.
REQ-022 In IDLE, all mem_* outputs and both resp outputs SHALL be 0; grant decision is registered, so first downstream request appears the cycle after a request is seen.
REQ-023 IDLE transitions: only I requesting -> SERVE_I; only D (read or write) requesting -> SERVE_D; both -> the side opposite last_grant; none -> IDLE.
REQ-024 On entering SERVE_x, last_grant SHALL update to x.
REQ-025 SERVE_I: mem_read = i_pmem_read, mem_write = 0, mem_addr = i_pmem_addr, mem_wdata = 0, i_pmem_rdata = mem_rdata, i_pmem_resp = mem_resp; all D-side outputs 0.
REQ-026 SERVE_D: mem_read = d_pmem_read, mem_write = d_pmem_write, mem_addr = d_pmem_addr, mem_wdata = d_pmem_wdata, d_pmem_rdata = mem_rdata, d_pmem_resp = mem_resp; all I-side outputs 0.
REQ-027 Response paths SHALL be combinational (zero added latency from mem_resp to x_pmem_resp).
REQ-028 SERVE_x SHALL return to IDLE on the cycle mem_resp = 1; it stays in SERVE_x otherwise.
REQ-029 The mandatory IDLE cycle after every transaction guarantees mem_read and mem_write deassert for at least one cycle between transactions, which the downstream buffer uses to detect end of read.
REQ-030 If the served requester drops its request before mem_resp (protocol violation), the arbiter SHALL return to IDLE the next cycle without asserting any resp.
REQ-031 d_pmem_read and d_pmem_write both high SHALL be forwarded unchanged; resolving that case is not the arbiter's job.
REQ-032 mem_read and mem_write SHALL never both be driven by different requesters in the same cycle.

Reset
REQ-033 rst = 1 SHALL immediately force state = IDLE and last_grant = 0, and drive every output to 0, regardless of the current state.
REQ-034 A transaction in flight at reset SHALL be abandoned; a mem_resp arriving during or after reset in IDLE SHALL be ignored.

Verification
REQ-035 Single I read, addr 0x0000_1000, mem_resp on the 3rd granted cycle -> mem_read rises 1 cycle after request, i_pmem_resp pulses with rdata = mem_rdata, then IDLE.
REQ-036 I and D read both asserted from reset -> D served first (last_grant = 0), then a 1-cycle IDLE gap, then I; both complete.
REQ-037 D write, addr 0x0000_2040, with mem_resp same cycle as grant -> d_pmem_resp pulses in the first SERVE_D cycle, mem_write low the next cycle.
REQ-038 I and D requests held continuously for 6 transactions -> grants alternate D, I, D, I, D, I; no starvation.
REQ-039 rst asserted mid-SERVE_D, then mem_resp = 1 -> all outputs 0 asynchronously; no d_pmem_resp; state IDLE.
REQ-040 Back-to-back D reads -> mem_read is low for exactly one cycle between the two transactions.
